fwperiph_dma_xfer_engine: RTL and testbench
===========================================

# fwperiph_dma_xfer_engine

Four-channel transfer engine of the fwperiph DMA. It sits between the channel register file, which is written through the register-initiator port, and the memory-initiator port, which the mem_init agent models in the 4-channel bench. It takes per-channel start requests (source, destination, word count) and arbitrates round-robin between channels in bursts of at most BURST_LEN words. Each word is moved as one read followed by one write on a single-outstanding valid/ready memory bus.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; address stride per word = DATA_W/8
- CNT_W, 16, word-count width
- BURST_LEN, 4, maximum words per grant before re-arbitration (≥1)
- clock  in  1  sole clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- chan_start  in  4  one-cycle start pulse per channel
- chan_src  in  4*ADDR_W  source byte address, channel i at [i*ADDR_W +: ADDR_W]
- chan_dst  in  4*ADDR_W  destination byte address, same packing
- chan_cnt  in  4*CNT_W  word count, same packing
- chan_busy  out  4  channel has an accepted, unfinished transfer
- chan_done  out  4  one-cycle pulse when a channel's transfer completes
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory request accepted
- mem_req_we  out  1  1 = write, 0 = read
- mem_req_addr  out  ADDR_W  byte address
- mem_req_wdata  out  DATA_W  write data
- mem_rsp_valid  in  1  response valid; one response per accepted request; read data or write ack
- mem_rsp_rdata  in  DATA_W  read data

## Operation
- Per-channel working registers: cur_src, cur_dst, remaining.
- Start handling:
  - chan_start[i] with chan_busy[i]=0 loads the working registers from the chan_* inputs and sets busy[i].
  - chan_start[i] while busy[i]=1 is ignored.
- Zero count: a start with chan_cnt=0 never wins arbitration. It produces chan_done[i] on the cycle after busy rises, with no bus traffic.
- States: ARB, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT. Reset state is ARB.
- ARB:
  - Pick the first busy channel with remaining≠0, scanning from rr_ptr upward modulo 4.
  - On a grant: go to RD_REQ, set rr_ptr = grant+1, clear burst_cnt.
  - No eligible channel: stay in ARB.
- RD_REQ: valid=1, we=0, addr=cur_src. On ready, go to RD_WAIT.
- RD_WAIT: on rsp_valid, capture rdata into the data register and go to WR_REQ.
- WR_REQ: valid=1, we=1, addr=cur_dst, wdata=captured data. On ready, go to WR_WAIT.
- WR_WAIT: on rsp_valid:
  - cur_src += DATA_W/8, cur_dst += DATA_W/8, remaining -= 1, burst_cnt += 1.
  - If remaining becomes 0: clear busy[i], pulse done[i], go to ARB.
  - Else if burst_cnt reaches BURST_LEN: go to ARB.
  - Else: go to RD_REQ.
- Addresses wrap modulo 2^ADDR_W. No error is raised on wrap.
- mem_req_addr/we/wdata stay stable while valid=1 and ready=0. valid never drops before ready.
- A start for a channel that is not currently granted can be accepted on any cycle. It does not disturb the transfer in flight.
- rsp_valid outside RD_WAIT/WR_WAIT is ignored.

## Timing
- Reset values:
  - chan_busy=0, chan_done=0.
  - mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0.
  - rr_ptr=0, state=ARB.
- Reset asserted mid-transfer:
  - All outputs go to reset values immediately (asynchronous).
  - The in-flight request is dropped and a late response is ignored.
  - No done pulse is issued.
- Latency, with start at cycle N on an idle engine:
  - busy=1 at N+1.
  - ARB grants at N+1.
  - mem_req_valid=1 (read) at N+2.
- Zero-wait memory (ready in the same cycle as valid, rsp the cycle after acceptance):
  - 4 cycles per word: RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
  - 1 extra ARB cycle per grant.
- Done pulse: done[i] rises, and busy[i] falls, on the cycle after the final write response is sampled. The pulse lasts exactly 1 cycle.
- Two starts in the same cycle are both accepted. Grant order follows rr_ptr.

## Test plan
- Reset, then ch0 start src=0x1000 dst=0x2000 cnt=3 → reads 0x1000/0x1004/0x1008, each followed by a write to 0x2000/0x2004/0x2008 with matching data. One done[0] pulse; busy[0] high throughout.
- ch0 and ch2 started in the same cycle, cnt=8 each, BURST_LEN=4 → grant order ch0(4 words), ch2(4), ch0(4), ch2(4). done[0] precedes done[2].
- cnt=0 start on ch1 → done[1] two cycles after start, no mem_req_valid.
- Random ready backpressure (0–5 wait cycles) → addr/we/wdata stable while valid && !ready. Data integrity holds for 64 words.
- ch3 src=0xFFFF_FFFC cnt=2 → second read at 0x0000_0000.
- reset_n dropped during WR_WAIT of a cnt=5 transfer → valid=0 and busy=0 immediately, no done pulse. A new start after release runs normally.

Source files
------------

// File: rtl/fwperiph_dma_xfer_engine_if.sv
// Memory-initiator bus of the fwperiph DMA: single-outstanding valid/ready
// request channel plus a response strobe carrying read data or a write ack.
interface fwperiph_dma_xfer_engine_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/fwperiph_dma_xfer_engine.sv
// Four-channel DMA transfer engine: round-robin grants of up to BURST_LEN
// words, each word moved as one read then one write on the memory bus.
module fwperiph_dma_xfer_engine #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int BURST_LEN = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [3:0]            chan_start,
  input  logic [4*ADDR_W-1:0]   chan_src,
  input  logic [4*ADDR_W-1:0]   chan_dst,
  input  logic [4*CNT_W-1:0]    chan_cnt,
  output logic [3:0]            chan_busy,
  output logic [3:0]            chan_done,
  fwperiph_dma_xfer_engine_if.master mem
);

  localparam int BC_W = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

  typedef enum logic [2:0] {ARB, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

  state_t            state;
  logic [1:0]        rr_ptr;
  logic [1:0]        grant;
  logic [1:0]        pick;
  logic              pick_vld;
  logic [BC_W-1:0]   burst_cnt;
  logic [BC_W-1:0]   burst_nxt;
  logic [ADDR_W-1:0] cur_src   [4];
  logic [ADDR_W-1:0] cur_dst   [4];
  logic [CNT_W-1:0]  remaining [4];
  logic              word_ack;
  logic              last_word;

  assign word_ack  = (state == WR_WAIT) && mem.mem_rsp_valid;
  assign last_word = (remaining[grant] == CNT_W'(1));
  assign burst_nxt = burst_cnt + BC_W'(1);

  // First eligible channel at or after rr_ptr; zero-count channels never qualify.
  always_comb begin
    pick_vld = 1'b0;
    pick     = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      if (!pick_vld && chan_busy[rr_ptr + 2'(k)] &&
          (remaining[rr_ptr + 2'(k)] != '0)) begin
        pick_vld = 1'b1;
        pick     = rr_ptr + 2'(k);
      end
    end
  end

  // Working registers are pure datapath; busy gates whether they mean anything.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (chan_start[i] && !chan_busy[i]) begin
        cur_src[i]   <= chan_src[i*ADDR_W +: ADDR_W];
        cur_dst[i]   <= chan_dst[i*ADDR_W +: ADDR_W];
        remaining[i] <= chan_cnt[i*CNT_W +: CNT_W];
      end else if (word_ack && (grant == 2'(i))) begin
        cur_src[i]   <= cur_src[i] + STRIDE;
        cur_dst[i]   <= cur_dst[i] + STRIDE;
        remaining[i] <= remaining[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ARB;
      rr_ptr            <= 2'd0;
      grant             <= 2'd0;
      burst_cnt         <= '0;
      chan_busy         <= 4'd0;
      chan_done         <= 4'd0;
      mem.mem_req_valid <= 1'b0;
      mem.mem_req_we    <= 1'b0;
      mem.mem_req_addr  <= '0;
      mem.mem_req_wdata <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        chan_done[i] <= 1'b0;
        if (chan_start[i] && !chan_busy[i]) begin
          chan_busy[i] <= 1'b1;
        end else if (chan_busy[i] && (remaining[i] == '0)) begin
          // zero-count start: retire without ever being granted
          chan_busy[i] <= 1'b0;
          chan_done[i] <= 1'b1;
        end else if (word_ack && (grant == 2'(i)) && last_word) begin
          chan_busy[i] <= 1'b0;
          chan_done[i] <= 1'b1;
        end
      end

      case (state)
        ARB: begin
          if (pick_vld) begin
            grant             <= pick;
            rr_ptr            <= pick + 2'd1;
            burst_cnt         <= '0;
            state             <= RD_REQ;
            mem.mem_req_valid <= 1'b1;
            mem.mem_req_we    <= 1'b0;
            mem.mem_req_addr  <= cur_src[pick];
          end
        end
        RD_REQ: begin
          if (mem.mem_req_ready) begin
            mem.mem_req_valid <= 1'b0;
            state             <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem.mem_rsp_valid) begin
            mem.mem_req_wdata <= mem.mem_rsp_rdata;
            mem.mem_req_addr  <= cur_dst[grant];
            mem.mem_req_we    <= 1'b1;
            mem.mem_req_valid <= 1'b1;
            state             <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (mem.mem_req_ready) begin
            mem.mem_req_valid <= 1'b0;
            state             <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (mem.mem_rsp_valid) begin
            burst_cnt <= burst_nxt;
            if (last_word || (burst_nxt == BC_W'(BURST_LEN))) begin
              state <= ARB;
            end else begin
              // cur_src advances on this same edge, so issue the next address directly
              state             <= RD_REQ;
              mem.mem_req_valid <= 1'b1;
              mem.mem_req_we    <= 1'b0;
              mem.mem_req_addr  <= cur_src[grant] + STRIDE;
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_fwperiph_dma_xfer_engine.sv
// Self-checking bench for fwperiph_dma_xfer_engine: table vectors, hand-written
// latency/reset sequences and randomized runs against a transaction-level model.
module tb_fwperiph_dma_xfer_engine;

  localparam int ADDR_W = 32, DATA_W = 32, CNT_W = 16, BURST_LEN = 4;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic [3:0]          chan_start = 4'd0;
  logic [4*ADDR_W-1:0] chan_src = '0;
  logic [4*ADDR_W-1:0] chan_dst = '0;
  logic [4*CNT_W-1:0]  chan_cnt = '0;
  logic [3:0]          chan_busy;
  logic [3:0]          chan_done;

  fwperiph_dma_xfer_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  fwperiph_dma_xfer_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .BURST_LEN(BURST_LEN)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .chan_start (chan_start),
    .chan_src   (chan_src),
    .chan_dst   (chan_dst),
    .chan_cnt   (chan_cnt),
    .chan_busy  (chan_busy),
    .chan_done  (chan_done),
    .mem        (mem_if)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic [3:0]   mask;
    logic [127:0] src;
    logic [127:0] dst;
    logic [63:0]  cnt;
    int           wait_max;
    bit           noise;
    int           exp_words;
    int           exp_first;
  } vec_t;

  txn_t        exp_q[$];
  int          exp_done[$];
  int          done_log[$];
  int          done_cyc[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] seed;
  int          m_rr = 0;

  int wait_max = 0, rsp_min = 0, rsp_max = 0;
  bit noise = 0;
  int wr_count = 0, valid_cycles = 0;
  int inject_req = 0, inject_ack = 0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ seed[31:16], a[31:16] ^ seed[15:0]};
  endfunction

  function automatic logic [127:0] p32(input logic [31:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [63:0] p16(input logic [15:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic int find_cyc(input int base, input int ch);
    for (int j = base; j < done_log.size(); j++)
      if (done_log[j] == ch) return done_cyc[j];
    return -1;
  endfunction

  // Expected bus traffic: round-robin over channels with work, min(BURST_LEN, left) words per grant.
  task automatic build_model(input logic [3:0] mask, input logic [127:0] src, dst, input logic [63:0] cnt);
    logic [31:0] s[4], d[4];
    int r[4];
    bit found;
    int n, c;
    txn_t t;
    exp_done.delete();
    for (int i = 0; i < 4; i++) begin
      s[i] = src[i*32 +: 32];
      d[i] = dst[i*32 +: 32];
      r[i] = 0;
      if (mask[i]) begin
        r[i] = int'(cnt[i*16 +: 16]);
        if (r[i] == 0) exp_done.push_back(i);
      end
    end
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int k = 0; k < 4 && !found; k++) begin
        c = (m_rr + k) % 4;
        if (r[c] > 0) begin
          found = 1'b1;
          n = (r[c] < BURST_LEN) ? r[c] : BURST_LEN;
          for (int w = 0; w < n; w++) begin
            t.we = 1'b0; t.addr = s[c]; t.data = mem_read(s[c]);
            exp_q.push_back(t);
            t.we = 1'b1; t.addr = d[c];
            exp_q.push_back(t);
            s[c] += 32'd4;
            d[c] += 32'd4;
            r[c]--;
          end
          if (r[c] == 0) exp_done.push_back(c);
          m_rr = (c + 1) % 4;
        end
      end
    end
  endtask

  // Memory agent: random ready stall, delayed response, optional stray rsp_valid noise.
  initial begin
    bit pend, outst, stall;
    int wait_left, rsp_timer;
    txn_t cur, e;
    logic [31:0] rd_hold;
    pend = 0; outst = 0; stall = 0; wait_left = -1; rsp_timer = 0; rd_hold = '0;
    cur.we = 0; cur.addr = '0; cur.data = '0;
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_rdata = '0;
    forever begin
      @(posedge clock); #1;
      if (!reset_n) begin
        pend = 0; outst = 0; stall = 0; wait_left = -1;
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b0;
      end else begin
        if (stall)
          check("req_stable", {mem_if.mem_req_valid, mem_if.mem_req_we, mem_if.mem_req_addr, mem_if.mem_req_wdata},
                              {1'b1, cur.we, cur.addr, cur.data});
        stall = 0;
        if (pend) begin
          outst = 1; pend = 0;
          rsp_timer = $urandom_range(rsp_min, rsp_max);
        end
        mem_if.mem_rsp_valid = 1'b0;
        if (outst) begin
          if (rsp_timer == 0) begin
            mem_if.mem_rsp_valid = 1'b1;
            mem_if.mem_rsp_rdata = cur.we ? $urandom : rd_hold;
            outst = 0;
          end else rsp_timer--;
        end else if (inject_ack != inject_req) begin
          mem_if.mem_rsp_valid = 1'b1;
          mem_if.mem_rsp_rdata = $urandom;
          inject_ack++;
        end else if (noise && $urandom_range(0, 7) == 0) begin
          mem_if.mem_rsp_valid = 1'b1;
          mem_if.mem_rsp_rdata = $urandom;
        end
        mem_if.mem_req_ready = 1'b0;
        if (mem_if.mem_req_valid) begin
          if (wait_left < 0) begin
            check("single_outstanding", outst, 1'b0);
            wait_left = $urandom_range(0, wait_max);
          end
          cur.we = mem_if.mem_req_we; cur.addr = mem_if.mem_req_addr; cur.data = mem_if.mem_req_wdata;
          if (wait_left == 0) begin
            mem_if.mem_req_ready = 1'b1;
            pend = 1; wait_left = -1;
            if (cur.we) wr_count++;
            check("req_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("req_we", cur.we, e.we);
              check("req_addr", cur.addr, e.addr);
              if (e.we) check("wr_data", cur.data, e.data);
            end
            if (cur.we) mem[cur.addr] = cur.data;
            else rd_hold = mem_read(cur.addr);
          end else begin
            wait_left--;
            stall = 1;
          end
        end else if (noise) begin
          mem_if.mem_req_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Done/busy monitor, sampled mid-cycle.
  initial begin
    logic [3:0] prev_done;
    prev_done = 4'd0;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (mem_if.mem_req_valid) valid_cycles++;
        for (int i = 0; i < 4; i++) begin
          if (chan_done[i]) begin
            done_log.push_back(i);
            done_cyc.push_back(cyc);
            check("busy_low_at_done", chan_busy[i], 1'b0);
            check("done_pulse_width", prev_done[i], 1'b0);
          end
        end
        prev_done = chan_done;
      end else prev_done = 4'd0;
    end
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog expired actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    m_rr = 0;
    exp_q.delete();
    exp_done.delete();
  endtask

  task automatic run_case(input vec_t v, input int timeout);
    int base, wr0, vc0, n;
    wait_max = v.wait_max;
    noise    = v.noise;
    rsp_min  = 0;
    rsp_max  = (v.wait_max > 0) ? 2 : 0;
    build_model(v.mask, v.src, v.dst, v.cnt);
    base = done_log.size(); wr0 = wr_count; vc0 = valid_cycles;
    @(posedge clock); #1;
    chan_src = v.src; chan_dst = v.dst; chan_cnt = v.cnt; chan_start = v.mask;
    @(posedge clock); #1;
    chan_start = 4'd0;
    n = 0;
    while (n < timeout && (done_log.size() - base) < $countones(v.mask)) begin
      @(posedge clock); #1;
      n++;
    end
    check("done_timeout", n < timeout, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    check("all_txn_seen", exp_q.size(), 0);
    check("busy_idle", chan_busy, 4'd0);
    check("write_count", wr_count - wr0, v.exp_words);
    if (v.wait_max == 0) check("valid_cycles", valid_cycles - vc0, 2 * v.exp_words);
    for (int j = 0; j < exp_done.size(); j++)
      check("done_seq", (base + j < done_log.size()) ? done_log[base + j] : -1, exp_done[j]);
    if (v.exp_first >= 0)
      check("first_done", (base < done_log.size()) ? done_log[base] : -1, v.exp_first);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t v;
    int n0, m, base, n, wr0, vc0;

    seed = $urandom;
    vecs[0] = '{4'b0001, p32(32'h1000, 0, 0, 0), p32(32'h2000, 0, 0, 0), p16(3, 0, 0, 0), 0, 1'b0, 3, 0};
    vecs[1] = '{4'b0101, p32(32'h1100, 0, 32'h1300, 0), p32(32'h2100, 0, 32'h2300, 0), p16(8, 0, 8, 0), 0, 1'b0, 16, 0};
    vecs[2] = '{4'b0010, p32(0, 32'h1200, 0, 0), p32(0, 32'h2200, 0, 0), p16(0, 0, 0, 0), 0, 1'b0, 0, 1};
    vecs[3] = '{4'b1000, p32(0, 0, 0, 32'hFFFF_FFFC), p32(0, 0, 0, 32'h3000), p16(0, 0, 0, 2), 0, 1'b0, 2, 3};
    vecs[4] = '{4'b1111, p32(32'h1400, 32'h1500, 32'h1600, 32'h1700),
                p32(32'h2400, 32'h2500, 32'h2600, 32'h2700), p16(6, 2, 1, 5), 3, 1'b1, 14, 1};

    do_reset();
    #1;
    check("rst_busy", chan_busy, 4'd0);
    check("rst_done", chan_done, 4'd0);
    check("rst_valid", mem_if.mem_req_valid, 1'b0);
    check("rst_we", mem_if.mem_req_we, 1'b0);
    check("rst_addr", mem_if.mem_req_addr, 32'd0);
    check("rst_wdata", mem_if.mem_req_wdata, 32'd0);

    // Latency, ignored restart of a busy channel, zero-count start mid-transfer.
    wait_max = 0; noise = 0; rsp_min = 0; rsp_max = 0;
    chan_src = p32(32'h1000, 0, 0, 0); chan_dst = p32(32'h2000, 0, 0, 0); chan_cnt = p16(3, 0, 0, 0);
    build_model(4'b0001, chan_src, chan_dst, chan_cnt);
    base = done_log.size();
    @(posedge clock); #1;
    chan_start = 4'b0001; n0 = cyc;
    @(posedge clock); #1;
    chan_start = 4'd0;
    check("busy_after_start", chan_busy[0], 1'b1);
    check("no_req_in_arb", mem_if.mem_req_valid, 1'b0);
    @(posedge clock); #1;
    check("first_req_valid", mem_if.mem_req_valid, 1'b1);
    check("first_req_we", mem_if.mem_req_we, 1'b0);
    check("first_req_addr", mem_if.mem_req_addr, 32'h1000);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chan_src = p32(32'hDEAD_0000, 32'h1800, 0, 0); chan_cnt = p16(9, 0, 0, 0);
    chan_start = 4'b0011; m = cyc;
    @(posedge clock); #1;
    chan_start = 4'd0;
    n = 0;
    while (n < 200 && (done_log.size() - base) < 2) begin
      @(posedge clock); #1;
      n++;
    end
    check("latency_timeout", n < 200, 1'b1);
    check("zero_cnt_done_cycle", find_cyc(base, 1), m + 2);
    check("ch0_done_cycle", find_cyc(base, 0), n0 + 14);
    repeat (2) @(posedge clock);
    #1;
    check("restart_ignored", exp_q.size(), 0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      run_case(vecs[i], 2000);
    end

    // Reset while a write response is pending.
    do_reset();
    wait_max = 0; noise = 0; rsp_min = 3; rsp_max = 3;
    chan_src = p32(32'h4000, 0, 0, 0); chan_dst = p32(32'h5000, 0, 0, 0); chan_cnt = p16(5, 0, 0, 0);
    build_model(4'b0001, chan_src, chan_dst, chan_cnt);
    base = done_log.size(); wr0 = wr_count;
    @(posedge clock); #1;
    chan_start = 4'b0001;
    @(posedge clock); #1;
    chan_start = 4'd0;
    n = 0;
    while (n < 200 && (wr_count - wr0) < 2) begin
      @(posedge clock); #1;
      n++;
    end
    check("wr_wait_timeout", n < 200, 1'b1);
    @(posedge clock); #2;
    check("busy_before_reset", chan_busy[0], 1'b1);
    reset_n = 1'b0;
    #1;
    check("midrst_valid", mem_if.mem_req_valid, 1'b0);
    check("midrst_busy", chan_busy, 4'd0);
    check("midrst_done", chan_done, 4'd0);
    check("midrst_addr", mem_if.mem_req_addr, 32'd0);
    check("midrst_wdata", mem_if.mem_req_wdata, 32'd0);
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    m_rr = 0; exp_q.delete(); rsp_min = 0; rsp_max = 0;
    vc0 = valid_cycles;
    inject_req++;
    repeat (10) @(posedge clock);
    #1;
    check("no_done_after_reset", done_log.size() - base, 0);
    check("no_req_after_reset", valid_cycles - vc0, 0);
    check("idle_after_reset", chan_busy, 4'd0);
    v = '{4'b0100, p32(0, 0, 32'h4800, 0), p32(0, 0, 32'h5800, 0), p16(0, 0, 3, 0), 0, 1'b0, 3, 2};
    run_case(v, 1000);

    // Randomized runs; the first moves 64 words under backpressure.
    do_reset();
    for (int r = 0; r < 5; r++) begin
      v.mask = (r == 0) ? 4'hF : 4'($urandom_range(1, 15));
      v.exp_words = 0;
      for (int ch = 0; ch < 4; ch++) begin
        v.src[ch*32 +: 32] = 32'h0010_0000 + 32'(ch) * 32'h1_0000 + 32'($urandom_range(0, 255)) * 32'd4;
        v.dst[ch*32 +: 32] = 32'h8000_0000 + 32'(r) * 32'h1000 + 32'(ch) * 32'h100;
        v.cnt[ch*16 +: 16] = (r == 0) ? 16'd16 : 16'($urandom_range(0, 12));
        if (v.mask[ch]) v.exp_words += int'(v.cnt[ch*16 +: 16]);
      end
      v.wait_max  = (r == 0) ? 5 : $urandom_range(0, 5);
      v.noise     = 1'b1;
      v.exp_first = -1;
      run_case(v, 4000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
